// File: rtl/mld_serial_decoder.sv
// mld_serial_decoder: serial one-step majority-logic decoder for cyclic
// LDPC/EG codes.
// The decoder accepts a word, rotates it N times and votes on the MSB at
// each step. It then holds the corrected word until the sink takes it.
// Optional build macro MLD_STATS_EN adds delivery and correction
// counters with a synchronous clear.
module mld_serial_decoder #(
    parameter int              N        = 15,
    parameter int              J        = 4,
    parameter int              THRESH   = J/2+1,
    parameter logic [J*N-1:0]  CHK_MASK = {15'h4580, 15'h4045, 15'h6022, 15'h5808},
    parameter int              CW       = $clog2(N+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_cw,
    input  logic          byp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_cw,
    output logic [CW-1:0] out_flips
`ifdef MLD_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_words,
    output logic [15:0]   stat_corr
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t          state_r;
    logic [N-1:0]    ct_r;
    logic [CW-1:0]   step_r;
    logic [CW-1:0]   flips_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [N-1:0]    out_cw_r;
    logic [CW-1:0]   out_flips_r;

    logic [J-1:0]    s_s;
    logic [31:0]     cnt_s;
    logic            flip_s;
    logic [N-1:0]    rot_s;
    logic [CW-1:0]   flips_nx_s;

    // Even-parity of the selected taps of one check sum
    function automatic logic par_fn(input logic [N-1:0] v);
        par_fn = ^v;
    endfunction

    // Number of failing check sums
    function automatic logic [31:0] pop_fn(input logic [J-1:0] v);
        logic [31:0] c;
        c = 32'd0;
        for (int k = 0; k < J; k++) begin
            c = c + {31'd0, v[k]};
        end
        pop_fn = c;
    endfunction

    // Check sums, majority vote and the rotated/corrected next word
    always_comb begin
        s_s = '0;
        for (int j = 0; j < J; j++) begin
            s_s[j] = par_fn(ct_r & CHK_MASK[j*N +: N]);
        end
        cnt_s  = pop_fn(s_s);
        flip_s = (cnt_s >= $unsigned(THRESH));
        rot_s  = {ct_r[N-2:0], ct_r[N-1] ^ flip_s};
        if (flip_s && (flips_r != CW'(N))) begin
            flips_nx_s = flips_r + CW'(1);
        end else begin
            flips_nx_s = flips_r;
        end
    end

`ifdef MLD_STATS_EN
    logic        byp_r;
    logic [15:0] stat_words_r;
    logic [15:0] stat_corr_r;
`endif

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ct_r        <= '0;
            step_r      <= '0;
            flips_r     <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_cw_r    <= '0;
            out_flips_r <= '0;
`ifdef MLD_STATS_EN
            byp_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_ready_r && in_valid) begin
                        ct_r       <= in_cw;
                        step_r     <= '0;
                        flips_r    <= '0;
                        in_ready_r <= 1'b0;
`ifdef MLD_STATS_EN
                        byp_r      <= byp;
`endif
                        if (byp) begin
                            out_cw_r    <= in_cw;
                            out_flips_r <= '0;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            state_r     <= ST_DECODE;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    ct_r    <= rot_s;
                    flips_r <= flips_nx_s;
                    step_r  <= step_r + CW'(1);
                    // The last rotation restores the original bit alignment
                    if (step_r == CW'(N-1)) begin
                        out_cw_r    <= rot_s;
                        out_flips_r <= flips_nx_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MLD_STATS_EN
    // Saturating delivery/correction counters; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_r <= 16'd0;
            stat_corr_r  <= 16'd0;
        end else if (stat_clr) begin
            stat_words_r <= 16'd0;
            stat_corr_r  <= 16'd0;
        end else if ((state_r == ST_HOLD) && out_ready && !byp_r) begin
            if (stat_words_r != 16'hFFFF) begin
                stat_words_r <= stat_words_r + 16'd1;
            end
            if ((out_flips_r != '0) && (stat_corr_r != 16'hFFFF)) begin
                stat_corr_r <= stat_corr_r + 16'd1;
            end
        end
    end

    assign stat_words = stat_words_r;
    assign stat_corr  = stat_corr_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_cw    = out_cw_r;
    assign out_flips = out_flips_r;

endmodule

// File: tb/tb_mld_serial_decoder.sv
// Self-checking bench for mld_serial_decoder (default (15,7) parameters).
// A behavioural majority-logic model built from integer arithmetic
// produces the expected words. Directed vectors cover the reset,
// single/double-error, bypass, back-pressure and mid-decode reset cases.
// Randomized words follow.
module tb_mld_serial_decoder;

    localparam int N = 15;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_cw;
    logic          byp;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_cw;
    logic [3:0]    out_flips;
`ifdef MLD_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_words;
    logic [15:0]   stat_corr;
    int            exp_words;
    int            exp_corr;
`endif

    int n_vec;
    int n_err;

    mld_serial_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .byp       (byp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_cw    (out_cw),
        .out_flips (out_flips)
`ifdef MLD_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_words(stat_words),
        .stat_corr (stat_corr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Majority-logic decoding straight from the rules: N rounds of
    // vote-on-MSB then rotate left.
    function automatic void ref_decode(input logic [N-1:0] w_in, output logic [N-1:0] w_out, output int nf);
        int m [4];
        int w;
        int cnt;
        int f;
        int msb;
        m[0] = 32'h5808; m[1] = 32'h6022; m[2] = 32'h4045; m[3] = 32'h4580;
        w  = int'(w_in);
        nf = 0;
        for (int k = 0; k < N; k++) begin
            cnt = 0;
            for (int j = 0; j < 4; j++) begin
                if (($countones(w & m[j]) % 2) == 1) cnt++;
            end
            f = (cnt >= 3) ? 1 : 0;
            nf = nf + f;
            msb = ((w >> 14) & 1) ^ f;
            w = ((w << 1) & 32'h7FFE) | msb;
        end
        w_out = w[N-1:0];
    endfunction

    // Push one word through and check latency, result and handshakes
    task automatic run_word(input logic [N-1:0] w, input logic b, input int hold,
                            input logic [N-1:0] exp_cw, input int exp_fl);
        int guard;
        int lat;
        logic [N-1:0] cw_seen;
        guard = 0;
        @(negedge clk);
        in_cw     = w;
        byp       = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("accept_wait", {31'd0, guard < 50}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cw    = N'($urandom);
        byp      = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("latency", lat, b ? 32'd1 : 32'(N + 1));
        check_eq("out_cw", {17'd0, out_cw}, {17'd0, exp_cw});
        check_eq("out_flips", {28'd0, out_flips}, exp_fl);
        cw_seen = out_cw;
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                in_valid = 1'b1;
                in_cw    = ~w;
                byp      = 1'b0;
            end
            @(posedge clk);
            #1;
            check_eq("hold_cw", {17'd0, out_cw}, {17'd0, cw_seen});
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_valid", {31'd0, out_valid}, 32'd0);
        check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MLD_STATS_EN
        if (!b) begin
            if (exp_words < 65535) exp_words++;
            if (exp_fl != 0 && exp_corr < 65535) exp_corr++;
        end
        check_eq("stat_words", {16'd0, stat_words}, exp_words);
        check_eq("stat_corr", {16'd0, stat_corr}, exp_corr);
`endif
    endtask

    initial begin
        logic [N-1:0] w;
        logic [N-1:0] mw;
        logic         b;
        int           mf;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_cw = '0;
        byp = 1'b0;
        out_ready = 1'b1;
`ifdef MLD_STATS_EN
        stat_clr = 1'b0;
        exp_words = 0;
        exp_corr = 0;
`endif
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_cw", {17'd0, out_cw}, 32'd0);
        check_eq("rst_out_flips", {28'd0, out_flips}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready_high", {31'd0, in_ready}, 32'd1);

        // All-ones codeword, all single-error positions, double errors
        run_word(15'h7FFF, 1'b0, 0, 15'h7FFF, 0);
        for (int i = 0; i < N; i++) begin
            w = 15'h0001 << i;
            run_word(w, 1'b0, 0, 15'h0000, 1);
        end
        run_word(15'h4001, 1'b0, 0, 15'h0000, 2);
        run_word(15'h7FFF ^ 15'h0104, 1'b0, 0, 15'h7FFF, 2);

        // Bypass and back-pressure
        run_word(15'h0020, 1'b1, 0, 15'h0020, 0);
        run_word(15'h0020, 1'b0, 10, 15'h0000, 1);
        run_word(15'h1234, 1'b1, 3, 15'h1234, 0);

        // Randomized words against the model
        for (int r = 0; r < 40; r++) begin
            w = N'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                w = ($urandom_range(0, 1) == 0) ? 15'h0000 : 15'h7FFF;
                w = w ^ (15'h0001 << $urandom_range(0, 14)) ^ (15'h0001 << $urandom_range(0, 14));
            end
            b = ($urandom_range(0, 3) == 0);
            ref_decode(w, mw, mf);
            if (b) begin
                mw = w;
                mf = 0;
            end
            run_word(w, b, $urandom_range(0, 3), mw, mf);
        end

        // Reset in the middle of a decode aborts the word
        @(negedge clk);
        in_cw = 15'h7FFF;
        byp = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("abort_out_cw", {17'd0, out_cw}, 32'd0);
`ifdef MLD_STATS_EN
        exp_words = 0;
        exp_corr = 0;
        check_eq("abort_stat_words", {16'd0, stat_words}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_recover_in_ready", {31'd0, in_ready}, 32'd1);
        run_word(15'h0000, 1'b0, 0, 15'h0000, 0);
`ifdef MLD_STATS_EN
        check_eq("stat_words_one", {16'd0, stat_words}, 32'd1);
        check_eq("stat_corr_zero", {16'd0, stat_corr}, 32'd0);
        run_word(15'h0100, 1'b0, 0, 15'h0000, 1);
        @(negedge clk);
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check_eq("stat_clr_words", {16'd0, stat_words}, 32'd0);
        check_eq("stat_clr_corr", {16'd0, stat_corr}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
